// File: rtl/sau_pkg.sv
// Shared encodings for the bit-serial arithmetic unit: operation modes and FSM states.
package sau_pkg;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUBB = 2'b10,
        MODE_SUBA = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder shared by every bit position of the serial datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_arith_unit.sv
// Bit-serial add/subtract unit: one result bit per clock, LSB first, valid/ready on both sides.
// Define SAU_FLAGS_EN to add the registered zero and signed-overflow flag outputs.
module serial_arith_unit
    import sau_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
`ifdef SAU_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int IDX_W = $clog2(WIDTH);

    state_e                  state;
    logic [IDX_W-1:0]        idx;
    logic                    carry;
    logic [WIDTH-1:0]        a_sh;
    logic [WIDTH-1:0]        b_sh;
    logic [WIDTH-1:0]        acc;
    logic                    fa_s;
    logic                    fa_co;
    logic                    accept;
    logic                    last_bit;
    logic [WIDTH-1:0]        result;

    // Operand inversion is folded in at capture so the serial loop only ever adds.
    function automatic logic [WIDTH-1:0] prep_a(input logic [1:0] m, input logic [WIDTH-1:0] x);
        return (mode_e'(m) == MODE_SUBA) ? ~x : x;
    endfunction

    function automatic logic [WIDTH-1:0] prep_b(input logic [1:0] m, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (mode_e'(m))
            MODE_INC:  r = '0;
            MODE_SUBB: r = ~y;
            default:   r = y;
        endcase
        return r;
    endfunction

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign last_bit = (idx == IDX_W'(WIDTH - 1));
    assign result   = {fa_s, acc[WIDTH-1:1]};

    fulladder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Datapath shift registers; contents are don't-care until a request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= prep_a(mode, a);
            b_sh <= prep_b(mode, b);
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= {fa_s, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
`ifdef SAU_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_co;
                    idx   <= idx + IDX_W'(1);
                    if (last_bit) begin
                        f         <= result;
                        cout      <= fa_co;
`ifdef SAU_FLAGS_EN
                        zero      <= (result == '0);
                        // carry still holds the carry into the MSB on this edge
                        ovf       <= carry ^ fa_co;
`endif
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            carry <= cin;
                            idx   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed self-checking bench for serial_arith_unit (WIDTH=8); flag checks enabled with SAU_FLAGS_EN.
module tb_serial_arith_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cin = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] f;
    logic       cout;
`ifdef SAU_FLAGS_EN
    logic       zero;
    logic       ovf;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int edges;

    serial_arith_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
`ifdef SAU_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit ready; returns #1 after the accepting edge.
    task automatic start_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y, input logic c);
        in_valid = 1'b1;
        mode     = m;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input bit scramble, output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            if (scramble) begin
                a    = 8'($urandom);
                b    = 8'($urandom);
                cin  = 1'($urandom);
                mode = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic [7:0] ef, input logic ec, input logic ez,
                         input logic eo, input bit scramble);
        int n;
        check({tag, "_rdy"}, in_ready, 1);
        start_op(m, x, y, c);
        check({tag, "_vld_early"}, out_valid, 0);
        wait_result(scramble, n);
        check({tag, "_lat"}, n, 8);
        check({tag, "_f"}, f, ef);
        check({tag, "_cout"}, cout, ec);
`ifdef SAU_FLAGS_EN
        check({tag, "_zero"}, zero, ez);
        check({tag, "_ovf"}, ovf, eo);
`else
        if (ez === 1'bx || eo === 1'bx) $display("note: bad flag args in %s", tag);
`endif
        @(posedge clk);
        #1;
        check({tag, "_vld_drop"}, out_valid, 0);
        check({tag, "_f_hold"}, f, ef);
    endtask

    initial begin
        #3;
        check("rst_vld", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_cout", cout, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("add_3c_0f", 2'b01, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("subb_05_07", 2'b10, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("inc_ff", 2'b00, 8'hFF, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("suba_01_01", 2'b11, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("add_7f_01", 2'b01, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("add_ff_ff", 2'b01, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("subb_07_05", 2'b10, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);

        // Consumer stall in DONE, then back-to-back accept on the release edge
        out_ready = 1'b0;
        start_op(2'b01, 8'h02, 8'h03, 1'b0);
        wait_result(1'b0, edges);
        check("stall_lat", edges, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_f", f, 8'h05);
            check("stall_cout", cout, 0);
            check("stall_vld", out_valid, 1);
            check("stall_rdy", in_ready, 0);
        end
        in_valid  = 1'b1;
        mode      = 2'b01;
        a         = 8'h10;
        b         = 8'h20;
        cin       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("b2b_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_vld_drop", out_valid, 0);
        check("b2b_run_rdy", in_ready, 0);
        wait_result(1'b0, edges);
        check("b2b_lat", edges, 8);
        check("b2b_f", f, 8'h30);
        check("b2b_cout", cout, 0);
        @(posedge clk);
        #1;

        // Reset mid-operation after four result bits
        start_op(2'b01, 8'h11, 8'h22, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_vld", out_valid, 0);
        check("abort_f", f, 0);
        check("abort_cout", cout, 0);
        check("abort_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("post_rst", 2'b01, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        // Inputs scrambled every cycle while the unit is running
        do_op("scr_suba", 2'b11, 8'h10, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        do_op("scr_add", 2'b01, 8'hA0, 8'h60, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_arith_unit.md
SERIAL_ARITH_UNIT -- requirements
Module: serial_arith_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  unit able to accept a request.
REQ-006 SHALL have port: mode  input  2  operation select (see REQ-012).
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: cin  input  1  carry-in to LSB.
REQ-010 SHALL have ports: out_valid output 1 result valid; out_ready input 1 consumer accepts; f output WIDTH result; cout output 1 carry-out of MSB.
REQ-011 SHALL have ports, present only with SAU_FLAGS_EN: zero output 1 (f==0); ovf output 1 (signed overflow).

Function
REQ-012 SHALL implement modes: 00 f=A+cin (B forced 0); 01 f=A+B+cin; 10 f=A+~B+cin; 11 f=~A+B+cin; {cout,f} is the full WIDTH+1-bit sum.
REQ-013 SHALL compute bit-serially, LSB first, one bit per clock, through a single 1-bit full adder and a carry flop.
REQ-014 SHALL use FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready, capturing mode, a, b, cin into internal registers and entering RUN with bit index 0.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-017 SHALL, in RUN, produce one result bit per edge; after the edge computing bit WIDTH-1 enter DONE.
REQ-018 SHALL assert out_valid exactly WIDTH rising edges after the accepting edge, only in DONE.
REQ-019 SHALL hold f, cout (and flags) stable while out_valid && !out_ready.
REQ-020 SHALL, in DONE with out_ready: go to RUN if in_valid (back-to-back accept, new operands captured same edge), else to IDLE.
REQ-021 SHALL ignore in_valid, mode, a, b, cin while in RUN; captured operands unaffected by input changes after acceptance.
REQ-022 SHALL keep f and cout at last result in IDLE (not cleared after handoff).

Reset
REQ-023 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, f=0, cout=0, carry flop=0, bit index=0, zero=0, ovf=0; in_ready=1 after.
REQ-024 SHALL abort any operation in RUN or DONE on reset; no partial result is ever presented.

Configuration
REQ-025 SHALL with macro SAU_FLAGS_EN defined provide zero (f==0) and ovf (carry into MSB XOR carry out of MSB), both valid with out_valid and registered with f.
REQ-026 SHALL without SAU_FLAGS_EN omit zero and ovf ports and their logic; all other behaviour identical.

Structure
REQ-027 SHALL place mode encodings (MODE_INC, MODE_ADD, MODE_SUBB, MODE_SUBA) and FSM state encodings in shared package sau_pkg.
REQ-028 SHALL instantiate exactly one sub-module, fulladder (1-bit a, b, cin -> s, cout).

Verification (WIDTH=8)
REQ-029 SHALL check: mode 01, a=3C, b=0F, cin=0 -> f=4B, cout=0, out_valid 8 edges after accept.
REQ-030 SHALL check: mode 10, a=05, b=07, cin=1 -> f=FE, cout=0; mode 00, a=FF, cin=1 -> f=00, cout=1.
REQ-031 SHALL check (SAU_FLAGS_EN): mode 11, a=01, b=01, cin=1 -> f=00, cout=1, zero=1; mode 01, a=7F, b=01, cin=0 -> f=80, ovf=1.
REQ-032 SHALL check: out_ready low 5 cycles in DONE -> f/cout stable, in_ready=0; then out_ready with in_valid high -> new op accepted same edge, no idle cycle.
REQ-033 SHALL check: rst_n pulsed low at bit 4 of RUN -> out_valid=0, f=00, in_ready=1 immediately; next op completes correctly.
REQ-034 SHALL check: operand inputs toggled randomly during RUN -> result equals captured operands' result.
